usb_protocol_ctrl: RTL and testbench
====================================

# usb_protocol_ctrl

Protocol-layer sequencer for the USB endpoint. It sits between `usb_rx`, `usb_tx`, the shared data buffer and the AHB-lite slave. It consumes decoded PIDs from `usb_rx`, decides the handshake or data response, and launches `usb_tx`. It tracks DATA0/DATA1 toggles per direction and owns the buffer-clear and bus-direction (`d_mode`) controls.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles allowed in any wait state before abort.
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `rx_packet`  in  4  PID from `usb_rx`; valid when `rx_data_ready`=1
- `rx_data_ready`  in  1  one-cycle pulse: packet received with good EOP
- `rx_error`  in  1  one-cycle pulse: `usb_rx` framing/CRC error
- `tx_transfer_active`  in  1  `usb_tx` busy
- `tx_error`  in  1  `usb_tx` abort pulse
- `tx_data_valid`  in  1  AHB side has IN data loaded in buffer
- `host_rx_read`  in  1  pulse: AHB side has drained OUT data
- `clear_error`  in  1  pulse: clears `error_flag`
- `tx_packet`  out  4  PID for `usb_tx`; held from launch until return to IDLE
- `tx_start`  out  1  one-cycle launch pulse to `usb_tx`
- `clear_buffer`  out  1  one-cycle buffer flush pulse
- `d_mode`  out  1  1 while the device drives the bus
- `rx_done`  out  1  pulse: new OUT payload accepted
- `tx_done`  out  1  pulse: IN payload acknowledged by host
- `error_flag`  out  1  sticky protocol error

## Operation
- PIDs: OUT=0001, IN=1001, DATA0=0011, DATA1=1011, ACK=0010, NAK=1010, STALL=1110.
- States: IDLE, WAIT_DATA, SEND, TX_LAUNCH, TX_BUSY, WAIT_HOST_ACK.
- IDLE:
  - `rx_data_ready` with OUT → WAIT_DATA.
  - With IN → SEND with DATA0/1 per `in_toggle` if `tx_data_valid`, else SEND with NAK.
  - Other PIDs are ignored.
- WAIT_DATA:
  - DATA PID matching `out_toggle` with `rx_pending`=0 → pulse `rx_done`, flip `out_toggle`, set `rx_pending`, SEND with ACK.
  - Toggle mismatch (duplicate) → pulse `clear_buffer`, SEND with ACK, no flip, no `rx_done`.
  - `rx_pending`=1 → pulse `clear_buffer`, SEND with NAK.
  - Any other PID, `rx_error`, or timeout → set `error_flag`, pulse `clear_buffer`, IDLE.
- SEND (exactly one cycle): `tx_start`=1, `tx_packet` latched → TX_LAUNCH.
- TX_LAUNCH: wait for `tx_transfer_active`=1 → TX_BUSY. Timeout → error, IDLE.
- TX_BUSY: when `tx_transfer_active`=0, go to WAIT_HOST_ACK if a DATA PID was sent, else IDLE. `tx_error` → error, IDLE.
- WAIT_HOST_ACK:
  - ACK → pulse `tx_done` and `clear_buffer`, flip `in_toggle`, IDLE.
  - NAK → IDLE; data retained, no toggle change.
  - `rx_error` or timeout → error, IDLE; data retained.
- `d_mode`=1 in SEND, TX_LAUNCH and TX_BUSY; 0 elsewhere.
- `rx_pending` clears on `host_rx_read`. A simultaneous set and clear leaves it set.
- `error_flag`: set has priority over `clear_error` in the same cycle.
- Timeout counter is `$clog2(TIMEOUT_CYCLES)+1` bits. It resets on each wait-state entry and fires when count == `TIMEOUT_CYCLES`-1.
- `rx_error` in IDLE sets `error_flag`; the state stays IDLE.

## Timing
- Reset (async, immediate, including mid-transfer): state IDLE; all outputs 0; `tx_packet`=0000; both toggles DATA0; `rx_pending`=0; counter 0.
- Outputs are registered or decoded from state only; no input-to-output combinational path.
- `rx_data_ready` sampled at edge N → SEND during cycle N+1 (`tx_start`, `tx_packet` valid). `rx_done`, `clear_buffer` and toggle updates are visible in cycle N+1.
- `tx_done` and `clear_buffer` appear in the cycle after the edge sampling the host ACK.
- Inputs `rx_data_ready` and `rx_error` in the same cycle: the error wins.

## Structure
- `usb_pkg`: PID localparams, state enum, `TIMEOUT_CYCLES` default.
- Sub-module `usb_timeout_counter`: clear/enable in, `expired` out, parameterized limit.
- FSM, toggle bits, `rx_pending` and `error_flag` live in `usb_protocol_ctrl`.

## Test plan
- OUT then DATA0, `rx_pending`=0 → cycle after: `rx_done`=1, `tx_start`=1, `tx_packet`=0010; `out_toggle`→1.
- Repeat OUT then DATA0 after `host_rx_read` → `clear_buffer`=1, ACK sent, no `rx_done`, `out_toggle` stays 1.
- IN with `tx_data_valid`=1; `tx_transfer_active` high 20 cycles; then host ACK → `tx_packet`=0011, `d_mode` high during TX, then `tx_done`=1 and `in_toggle`=1.
- IN with `tx_data_valid`=0 → `tx_packet`=1010, return to IDLE after TX, `tx_done`=0.
- OUT then no data for 1024 cycles → `error_flag`=1, `clear_buffer` pulse, IDLE. `clear_error` → `error_flag`=0.
- `n_rst` low during TX_BUSY → all outputs 0 immediately; next IN uses DATA0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared PID encodings, FSM state type and defaults for the USB protocol layer.
package usb_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SEND,
    TX_LAUNCH,
    TX_BUSY,
    WAIT_HOST_ACK
  } state_t;

  // DATA0 and DATA1 differ only in bit 3, which is the toggle value.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return pid[2:0] == 3'b011;
  endfunction

endpackage

// File: rtl/usb_timeout_counter.sv
// Wait-state watchdog: counts while enabled, restarts on clear, flags LIMIT-1.
module usb_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/usb_protocol_ctrl.sv
// Protocol-layer sequencer: decodes host tokens, picks handshake/data responses,
// launches usb_tx and tracks per-direction DATA0/DATA1 toggles.
module usb_protocol_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  input  logic       tx_data_valid,
  input  logic       host_rx_read,
  input  logic       clear_error,
  output logic [3:0] tx_packet,
  output logic       tx_start,
  output logic       clear_buffer,
  output logic       d_mode,
  output logic       rx_done,
  output logic       tx_done,
  output logic       error_flag
);

  state_t     state, next_state;
  logic [3:0] packet_d;
  logic       rx_done_d, clear_d, tx_done_d, err_set;
  logic       flip_out, flip_in, pend_set;
  logic       out_toggle, in_toggle, rx_pending;
  logic       expired, wait_state;

  assign wait_state = (state == WAIT_DATA) || (state == TX_LAUNCH) || (state == WAIT_HOST_ACK);

  usb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (next_state != state),
    .enable  (wait_state),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    packet_d   = tx_packet;
    rx_done_d  = 1'b0;
    clear_d    = 1'b0;
    tx_done_d  = 1'b0;
    err_set    = 1'b0;
    flip_out   = 1'b0;
    flip_in    = 1'b0;
    pend_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_error) begin
          err_set = 1'b1;
        end else if (rx_data_ready) begin
          if (rx_packet == PID_OUT) begin
            next_state = WAIT_DATA;
          end else if (rx_packet == PID_IN) begin
            next_state = SEND;
            packet_d   = tx_data_valid ? (in_toggle ? PID_DATA1 : PID_DATA0) : PID_NAK;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_error || expired) begin
          err_set    = 1'b1;
          clear_d    = 1'b1;
          next_state = IDLE;
        end else if (rx_data_ready) begin
          if (is_data_pid(rx_packet)) begin
            next_state = SEND;
            // A toggle mismatch is a host retry of data already accepted: ACK it again.
            if (rx_packet[3] != out_toggle) begin
              clear_d  = 1'b1;
              packet_d = PID_ACK;
            end else if (rx_pending) begin
              clear_d  = 1'b1;
              packet_d = PID_NAK;
            end else begin
              rx_done_d = 1'b1;
              flip_out  = 1'b1;
              pend_set  = 1'b1;
              packet_d  = PID_ACK;
            end
          end else begin
            err_set    = 1'b1;
            clear_d    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      SEND: next_state = TX_LAUNCH;
      TX_LAUNCH: begin
        if (expired) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else if (tx_transfer_active) begin
          next_state = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_error) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else if (!tx_transfer_active) begin
          next_state = is_data_pid(tx_packet) ? WAIT_HOST_ACK : IDLE;
        end
      end
      WAIT_HOST_ACK: begin
        if (rx_error || expired) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else if (rx_data_ready) begin
          if (rx_packet == PID_ACK) begin
            tx_done_d  = 1'b1;
            clear_d    = 1'b1;
            flip_in    = 1'b1;
            next_state = IDLE;
          end else if (rx_packet == PID_NAK) begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) packet_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      tx_packet    <= '0;
      rx_done      <= 1'b0;
      clear_buffer <= 1'b0;
      tx_done      <= 1'b0;
      error_flag   <= 1'b0;
      out_toggle   <= 1'b0;
      in_toggle    <= 1'b0;
      rx_pending   <= 1'b0;
    end else begin
      state        <= next_state;
      tx_packet    <= packet_d;
      rx_done      <= rx_done_d;
      clear_buffer <= clear_d;
      tx_done      <= tx_done_d;
      if (flip_out) out_toggle <= ~out_toggle;
      if (flip_in)  in_toggle  <= ~in_toggle;
      if (err_set)          error_flag <= 1'b1;
      else if (clear_error) error_flag <= 1'b0;
      if (pend_set)          rx_pending <= 1'b1;
      else if (host_rx_read) rx_pending <= 1'b0;
    end
  end

  assign tx_start = (state == SEND);
  assign d_mode   = (state == SEND) || (state == TX_LAUNCH) || (state == TX_BUSY);

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed bench for usb_protocol_ctrl with hand-computed expectations.
module tb_usb_protocol_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] rx_packet;
  logic       rx_data_ready, rx_error, tx_transfer_active, tx_error;
  logic       tx_data_valid, host_rx_read, clear_error;
  logic [3:0] tx_packet;
  logic       tx_start, clear_buffer, d_mode, rx_done, tx_done, error_flag;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  usb_protocol_ctrl #(.TIMEOUT_CYCLES(1024)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .rx_packet          (rx_packet),
    .rx_data_ready      (rx_data_ready),
    .rx_error           (rx_error),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_data_valid      (tx_data_valid),
    .host_rx_read       (host_rx_read),
    .clear_error        (clear_error),
    .tx_packet          (tx_packet),
    .tx_start           (tx_start),
    .clear_buffer       (clear_buffer),
    .d_mode             (d_mode),
    .rx_done            (rx_done),
    .tx_done            (tx_done),
    .error_flag         (error_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pid(input logic [3:0] pid);
    rx_packet     = pid;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
  endtask

  // Called in the SEND cycle; leaves the bench one cycle after TX_BUSY exits.
  task automatic run_tx(input int unsigned busy_cycles, input string tag);
    tick();
    check({tag, "_launch_start"}, tx_start, 1'b0);
    check({tag, "_launch_dmode"}, d_mode, 1'b1);
    tx_transfer_active = 1'b1;
    tick();
    for (int unsigned i = 0; i < busy_cycles; i++) begin
      if (i == 0 || i == busy_cycles - 1) check({tag, "_busy_dmode"}, d_mode, 1'b1);
      tick();
    end
    tx_transfer_active = 1'b0;
    tick();
    check({tag, "_post_dmode"}, d_mode, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    rx_packet = '0; rx_data_ready = 0; rx_error = 0; tx_transfer_active = 0;
    tx_error = 0; tx_data_valid = 0; host_rx_read = 0; clear_error = 0;
    tick(); tick();
    check("rst_packet", tx_packet, 4'b0000);
    check("rst_outs", {tx_start, clear_buffer, d_mode, rx_done, tx_done, error_flag}, 6'b0);
    n_rst = 1'b1;
    tick();

    // OUT + DATA0 accepted
    send_pid(4'b0001);
    check("out_wait_dmode", d_mode, 1'b0);
    send_pid(4'b0011);
    check("out_d0_rxdone", rx_done, 1'b1);
    check("out_d0_start", tx_start, 1'b1);
    check("out_d0_pkt", tx_packet, 4'b0010);
    check("out_d0_clr", clear_buffer, 1'b0);
    run_tx(3, "ack1");
    check("ack1_idle_pkt", tx_packet, 4'b0000);
    check("ack1_rxdone_gone", rx_done, 1'b0);

    // Duplicate DATA0 after host drains: ACK again, no rx_done
    host_rx_read = 1'b1; tick(); host_rx_read = 1'b0;
    send_pid(4'b0001);
    send_pid(4'b0011);
    check("dup_clr", clear_buffer, 1'b1);
    check("dup_rxdone", rx_done, 1'b0);
    check("dup_pkt", tx_packet, 4'b0010);
    run_tx(2, "dup");

    // DATA1 expected next (toggle stayed 1)
    send_pid(4'b0001);
    send_pid(4'b1011);
    check("d1_rxdone", rx_done, 1'b1);
    check("d1_pkt", tx_packet, 4'b0010);
    run_tx(2, "d1");

    // Matching DATA0 while payload still pending: NAK
    send_pid(4'b0001);
    send_pid(4'b0011);
    check("pend_pkt", tx_packet, 4'b1010);
    check("pend_clr", clear_buffer, 1'b1);
    check("pend_rxdone", rx_done, 1'b0);
    run_tx(2, "pend");
    host_rx_read = 1'b1; tick(); host_rx_read = 1'b0;

    // IN with data, 20 busy cycles, host ACK
    tx_data_valid = 1'b1;
    send_pid(4'b1001);
    check("in0_pkt", tx_packet, 4'b0011);
    check("in0_start", tx_start, 1'b1);
    run_tx(20, "in0");
    check("in0_hold_pkt", tx_packet, 4'b0011);
    check("in0_wait_txdone", tx_done, 1'b0);
    send_pid(4'b0010);
    check("in0_txdone", tx_done, 1'b1);
    check("in0_clr", clear_buffer, 1'b1);
    tick();
    check("in0_txdone_pulse", tx_done, 1'b0);

    // IN now uses DATA1; host NAK keeps toggle
    send_pid(4'b1001);
    check("in1_pkt", tx_packet, 4'b1011);
    run_tx(2, "in1");
    send_pid(4'b1010);
    check("in1_nak_txdone", tx_done, 1'b0);
    check("in1_nak_pkt", tx_packet, 4'b0000);
    send_pid(4'b1001);
    check("in1r_pkt", tx_packet, 4'b1011);
    run_tx(2, "in1r");
    send_pid(4'b0010);
    check("in1r_txdone", tx_done, 1'b1);

    // IN without data: NAK, straight back to IDLE
    tx_data_valid = 1'b0;
    send_pid(4'b1001);
    check("innak_pkt", tx_packet, 4'b1010);
    run_tx(2, "innak");
    check("innak_idle_pkt", tx_packet, 4'b0000);
    tick();
    check("innak_txdone", tx_done, 1'b0);

    // OUT with no data: timeout after 1024 cycles
    send_pid(4'b0001);
    repeat (1023) tick();
    check("to_before_err", error_flag, 1'b0);
    check("to_before_clr", clear_buffer, 1'b0);
    tick();
    check("to_err", error_flag, 1'b1);
    check("to_clr", clear_buffer, 1'b1);
    tick();
    check("to_clr_pulse", clear_buffer, 1'b0);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    check("clr_err", error_flag, 1'b0);

    // rx_error beats rx_data_ready and clear_error in IDLE
    rx_error = 1'b1; clear_error = 1'b1; tx_data_valid = 1'b1;
    send_pid(4'b1001);
    rx_error = 1'b0; clear_error = 1'b0;
    check("rxerr_flag", error_flag, 1'b1);
    check("rxerr_nostart", tx_start, 1'b0);
    clear_error = 1'b1; tick(); clear_error = 1'b0;

    // Set in_toggle to 1, then reset in TX_BUSY
    send_pid(4'b1001);
    check("pre_rst_pkt", tx_packet, 4'b0011);
    run_tx(2, "prerst");
    send_pid(4'b0010);
    send_pid(4'b1001);
    check("rst_in_pkt", tx_packet, 4'b1011);
    tick();
    tx_transfer_active = 1'b1;
    tick();
    check("rst_busy_dmode", d_mode, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_async_dmode", d_mode, 1'b0);
    check("rst_async_pkt", tx_packet, 4'b0000);
    tx_transfer_active = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    send_pid(4'b1001);
    check("post_rst_pkt", tx_packet, 4'b0011);
    run_tx(2, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
